// File: rtl/p3_pkg.sv
// p3_pkg: shared constants, FSM state type and the 5-bit window matcher
// for the program-3 pattern-count engine.
package p3_pkg;

  localparam logic [7:0] MSG_BASE = 8'd0;
  localparam int unsigned MSG_LEN = 32;
  localparam logic [7:0] PAT_ADDR = 8'd32;
  localparam logic [7:0] CTB_ADDR = 8'd67;
  localparam logic [7:0] CTO_ADDR = 8'd68;
  localparam logic [7:0] CTS_ADDR = 8'd69;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SCAN,
    S_WR67,
    S_WR68,
    S_WR69,
    S_DONE
  } state_t;

  // Counts how many of the four windows b[4:0], b[5:1], b[6:2], b[7:3]
  // equal pat (result 0..4).
  function automatic logic [2:0] win_count(input logic [7:0] b, input logic [4:0] pat);
    logic [2:0] n;
    n = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (b[k +: 5] == pat) n = n + 3'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/p3_if.sv
// p3_if: data-memory bus between the engine and its 256x8 memory.
//   addr/wr_en/wr_data/rd_data : main read/write port
//   rd2_addr/rd2_data          : second read port (next message byte)
interface p3_if;
  logic [7:0] addr;
  logic       wr_en;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic [7:0] rd2_addr;
  logic [7:0] rd2_data;

  modport master (output addr, wr_en, wr_data, rd2_addr, input rd_data, rd2_data);
  modport slave  (input addr, wr_en, wr_data, rd2_addr, output rd_data, rd2_data);
endinterface

// File: rtl/data_mem.sv
// data_mem: 256x8 memory `core`, asynchronous reads, synchronous write.
//   clk                        : write clock
//   addr/wr_en/wr_data/rd_data : read/write port
//   rd2_addr/rd2_data          : extra read-only port
// Contents are never reset.
module data_mem (
  input  logic       clk,
  input  logic [7:0] addr,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  input  logic [7:0] rd2_addr,
  output logic [7:0] rd2_data
);

  logic [7:0] core [256];

  always_ff @(posedge clk) begin
    if (wr_en) core[addr] <= wr_data;
  end

  assign rd_data  = core[addr];
  assign rd2_data = core[rd2_addr];

endmodule

// File: rtl/top_level_p3.sv
// top_level_p3: program-3 engine. After reset release, reads the pattern
// (core[32][7:3]) and the 32-byte message, counts in-byte matches (ctb),
// bytes with any match (cto) and matches over the whole bit string (cts),
// writes them to bytes 67/68/69 and raises done.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   done  : high once all results are written, until reset asserts
module top_level_p3
  import p3_pkg::*;
(
  input  logic clk,
  input  logic reset,
  output logic done
);

  p3_if bus ();

  data_mem dm1 (
    .clk      (clk),
    .addr     (bus.addr),
    .wr_en    (bus.wr_en),
    .wr_data  (bus.wr_data),
    .rd_data  (bus.rd_data),
    .rd2_addr (bus.rd2_addr),
    .rd2_data (bus.rd2_data)
  );

  state_t     state_q, state_d;
  logic [4:0] idx_q, idx_d;
  logic [4:0] pat_q, pat_d;
  logic [7:0] ctb_q, ctb_d;
  logic [7:0] cto_q, cto_d;
  logic [7:0] cts_q, cts_d;
  logic [2:0] inb;
  logic [2:0] crs;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      pat_q   <= '0;
      ctb_q   <= '0;
      cto_q   <= '0;
      cts_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pat_q   <= pat_d;
      ctb_q   <= ctb_d;
      cto_q   <= cto_d;
      cts_q   <= cts_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    pat_d        = pat_q;
    ctb_d        = ctb_q;
    cto_d        = cto_q;
    cts_d        = cts_q;
    inb          = '0;
    crs          = '0;
    bus.addr     = MSG_BASE + {3'b000, idx_q};
    bus.rd2_addr = MSG_BASE + {3'b000, idx_q} + 8'd1;
    bus.wr_en    = 1'b0;
    bus.wr_data  = '0;

    case (state_q)
      S_IDLE: state_d = S_LOAD;
      S_LOAD: begin
        bus.addr = PAT_ADDR;
        pat_d    = bus.rd_data[7:3];
        idx_d    = '0;
        state_d  = S_SCAN;
      end
      S_SCAN: begin
        inb = win_count(bus.rd_data, pat_q);
        // Crossing windows w[11:7]..w[8:4] of {core[i], core[i+1]} are the
        // in-byte windows of the 8-bit slice w[11:4].
        if (idx_q != 5'd31)
          crs = win_count({bus.rd_data[3:0], bus.rd2_data[7:4]}, pat_q);
        ctb_d = ctb_q + {5'b00000, inb};
        cto_d = cto_q + {7'b0000000, (inb != 3'd0)};
        cts_d = cts_q + {5'b00000, inb} + {5'b00000, crs};
        idx_d = idx_q + 5'd1;
        if (idx_q == 5'(MSG_LEN - 1)) state_d = S_WR67;
      end
      S_WR67: begin
        bus.addr    = CTB_ADDR;
        bus.wr_en   = 1'b1;
        bus.wr_data = ctb_q;
        state_d     = S_WR68;
      end
      S_WR68: begin
        bus.addr    = CTO_ADDR;
        bus.wr_en   = 1'b1;
        bus.wr_data = cto_q;
        state_d     = S_WR69;
      end
      S_WR69: begin
        bus.addr    = CTS_ADDR;
        bus.wr_en   = 1'b1;
        bus.wr_data = cts_q;
        state_d     = S_DONE;
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_top_level_p3.sv
module tb_top_level_p3;
  import p3_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic done;

  always #5 clk = ~clk;

  top_level_p3 dut (
    .clk   (clk),
    .reset (reset),
    .done  (done)
  );

  typedef struct {
    string        name;
    logic [255:0] msg;
    logic [4:0]   pat;
    int           ctb;
    int           cto;
    int           cts;
  } vec_t;

  typedef struct {
    string name;
    int    ctb;
    int    cto;
    int    cts;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] snap [256];
  int         checks = 0;
  int         failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference: ctb/cto per byte; cts by sliding over the whole 256-bit string.
  function automatic void model(input logic [255:0] m, input logic [4:0] p,
                                output int ctb, output int cto, output int cts);
    logic [7:0] b;
    int hits;
    ctb = 0; cto = 0; cts = 0;
    for (int j = 0; j < 32; j++) begin
      b = m[255 - 8*j -: 8];
      hits = 0;
      for (int k = 0; k < 4; k++) if (b[k +: 5] == p) hits++;
      ctb += hits;
      if (hits != 0) cto++;
    end
    for (int s = 0; s <= 251; s++) if (m[s +: 5] == p) cts++;
  endfunction

  task automatic load(input logic [255:0] m, input logic [4:0] p);
    logic [2:0] junk;
    reset = 1'b0;
    #1;
    for (int a = 0; a < 256; a++) dut.dm1.core[a] = 8'($urandom);
    for (int j = 0; j < 32; j++) dut.dm1.core[j] = m[255 - 8*j -: 8];
    junk = 3'($urandom);
    dut.dm1.core[32] = {p, junk};
    for (int a = 0; a < 256; a++) snap[a] = dut.dm1.core[a];
  endtask

  task automatic wait_done(input string name);
    int cyc;
    cyc = 0;
    while (done !== 1'b1 && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({name, "_latency"}, 32'(cyc), 32'd37);
  endtask

  task automatic check_results();
    exp_t e;
    int diff;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty actual=0 required=1");
      return;
    end
    e = sb.pop_front();
    chk({e.name, "_ctb"}, 32'(dut.dm1.core[67]), 32'(e.ctb));
    chk({e.name, "_cto"}, 32'(dut.dm1.core[68]), 32'(e.cto));
    chk({e.name, "_cts"}, 32'(dut.dm1.core[69]), 32'(e.cts));
    diff = 0;
    for (int a = 0; a < 256; a++)
      if (a < 67 || a > 69) if (dut.dm1.core[a] !== snap[a]) diff++;
    chk({e.name, "_mem_untouched"}, 32'(diff), 32'd0);
  endtask

  task automatic check_idle(input string name);
    chk({name, "_done"},  32'(done), 32'd0);
    chk({name, "_state"}, 32'(dut.state_q), 32'(S_IDLE));
    chk({name, "_ctrs"},  32'({dut.ctb_q, dut.cto_q, dut.cts_q}), 32'd0);
  endtask

  initial begin
    vec_t vecs[5];
    exp_t e;
    logic [255:0] rmsg;
    logic [4:0] rpat;
    int c1, c2, c3;

    vecs[0] = '{"zeros_p00000", '0, 5'b00000, 128, 32, 252};
    vecs[1] = '{"x55_p10101", {32{8'h55}}, 5'b10101, 64, 32, 126};
    vecs[2] = '{"zeros_p11111", '0, 5'b11111, 0, 0, 0};
    vecs[3] = '{"crossing_p11000", {8'h03, 248'd0}, 5'b11000, 0, 0, 1};
    for (int w = 0; w < 8; w++) rmsg[32*w +: 32] = $urandom;
    rpat = 5'($urandom);
    model(rmsg, rpat, c1, c2, c3);
    vecs[4] = '{"random", rmsg, rpat, c1, c2, c3};

    for (int i = 0; i < 5; i++) begin
      load(vecs[i].msg, vecs[i].pat);
      sb.push_back('{vecs[i].name, vecs[i].ctb, vecs[i].cto, vecs[i].cts});
      @(negedge clk);
      if (i == 0) check_idle("reset");
      reset = 1'b1;
      wait_done(vecs[i].name);
      check_results();
    end

    // Abort mid-scan, then full rerun.
    for (int w = 0; w < 8; w++) rmsg[32*w +: 32] = $urandom;
    rpat = rmsg[200 +: 5];
    load(rmsg, rpat);
    model(rmsg, rpat, e.ctb, e.cto, e.cts);
    e.name = "abort_rerun";
    sb.push_back(e);
    @(negedge clk);
    reset = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_idle("abort");
    repeat (2) @(posedge clk);
    #1;
    chk("abort_hold_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    wait_done("abort_rerun");
    check_results();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
